// File: rtl/mbox_pkg.sv
// Shared types and constants for the MBOX cycle arbiter.
//   tArbState     : arbiter state (idle, first cycle, busy, page-fail hold)
//   N_REQ_DEFAULT : default requester count
package mbox_pkg;

  localparam int unsigned N_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_T0,
    ARB_BUSY,
    ARB_HOLD
  } tArbState;

endpackage

// File: rtl/mbox_rr_pick.sv
// Combinational rotating-base priority picker.
// Returns the first set bit of vec at or after base, wrapping N-1 -> 0.
//   vec  in  N   candidate vector
//   base in  IW  starting index of the search
//   any  out 1   at least one bit of vec is set
//   idx  out IW  index of the winner (0 when any is low)
module mbox_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] base,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          hit;

  always_comb begin
    any  = |vec;
    idx  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(base) + i) % N);
      if (!hit && vec[cand]) begin
        idx = cand;
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbox_cyc_arbiter.sv
// MBOX memory-cycle arbiter. Grants one requester at a time: urgent class in fixed priority,
// normal class fixed or round-robin. The grant is held through retry and page-fail hold and is
// dropped on cycle completion or watchdog expiry.
//   clk, rst_n  clock, asynchronous active-low reset
//   req         per-source cycle request (sampled in idle only)
//   urgent      per-source urgent class qualifier
//   cyc_done    sequencer finished the granted cycle
//   retry       restart the granted cycle
//   pf_hold     page-fail hold, freezes the cycle and the watchdog
//   grant       registered one-hot grant
//   grant_idx   index of the grant, valid while cyc_active
//   cyc_t0      high on the first cycle of every granted or retried cycle
//   cyc_active  a grant is outstanding
//   to_err      one-cycle pulse on watchdog expiry
//   to_idx      sticky index of the last timed-out source
module mbox_cyc_arbiter
  import mbox_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEFAULT,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned TO_W    = 6,
  parameter int unsigned IW      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] urgent,
  input  logic             cyc_done,
  input  logic             retry,
  input  logic             pf_hold,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             cyc_t0,
  output logic             cyc_active,
  output logic             to_err,
  output logic [IW-1:0]    to_idx
);

  // Last BUSY count before expiry; the cycle that would reach 2**TO_W-1 is the expiry cycle.
  localparam logic [TO_W-1:0] WdogLast = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [IW-1:0]   IdxMax   = IW'(N_REQ - 1);

  tArbState         state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    to_idx_q, to_idx_d;
  logic             urg_q, urg_d;
  logic             to_err_q, to_err_d;
  logic [TO_W-1:0]  wdog_q, wdog_d;
  logic             leave;

  logic             urg_any, norm_any;
  logic [IW-1:0]    urg_idx, norm_idx, norm_base;

  assign norm_base = (RR_MODE != 0) ? rr_q : '0;

  mbox_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick_urg (
    .vec  (req & urgent),
    .base ('0),
    .any  (urg_any),
    .idx  (urg_idx)
  );

  mbox_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick_norm (
    .vec  (req & ~urgent),
    .base (norm_base),
    .any  (norm_any),
    .idx  (norm_idx)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    urg_d    = urg_q;
    to_err_d = 1'b0;
    to_idx_d = to_idx_q;
    wdog_d   = wdog_q;
    leave    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (urg_any || norm_any) begin
          state_d = ARB_T0;
          urg_d   = urg_any;
          idx_d   = urg_any ? urg_idx : norm_idx;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << idx_d;
          wdog_d  = '0;
        end
      end
      ARB_T0, ARB_BUSY: begin
        if (pf_hold) begin
          state_d = ARB_HOLD;
        end else if (retry) begin
          state_d = ARB_T0;
          wdog_d  = '0;
        end else if (cyc_done) begin
          leave = 1'b1;
        end else if (state_q == ARB_T0) begin
          state_d = ARB_BUSY;
          wdog_d  = '0;
        end else if (wdog_q == WdogLast) begin
          leave    = 1'b1;
          to_err_d = 1'b1;
          to_idx_d = idx_q;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ARB_HOLD: begin
        if (!pf_hold) begin
          state_d = ARB_BUSY;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (leave) begin
      state_d = ARB_IDLE;
      grant_d = '0;
      // Only normal-class grants advance the round-robin pointer.
      if (!urg_q) begin
        rr_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_q     <= '0;
      urg_q    <= 1'b0;
      to_err_q <= 1'b0;
      to_idx_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      urg_q    <= urg_d;
      to_err_q <= to_err_d;
      to_idx_q <= to_idx_d;
      wdog_q   <= wdog_d;
    end
  end

  assign grant      = grant_q;
  assign grant_idx  = idx_q;
  assign cyc_t0     = (state_q == ARB_T0);
  assign cyc_active = (state_q != ARB_IDLE);
  assign to_err     = to_err_q;
  assign to_idx     = to_idx_q;

endmodule

// File: tb/tb_mbox_cyc_arbiter.sv
// Randomized bench for mbox_cyc_arbiter (N_REQ=4, round-robin, TO_W=4) against a
// transaction-level reference model of the arbitration rules.
module tb_mbox_cyc_arbiter;

  localparam int N    = 4;
  localparam int TOW  = 4;
  localparam int LAST = (1 << TOW) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, urgent;
  logic       cyc_done, retry, pf_hold;
  logic [3:0] grant;
  logic [1:0] grant_idx, to_idx;
  logic       cyc_t0, cyc_active, to_err;

  int total = 0;
  int bad   = 0;

  // Reference model: current owner (-1 none), whether this is the first cycle of the owner's
  // memory cycle, whether frozen by page fail, BUSY cycles elapsed, round-robin start.
  int m_owner, m_busy, m_rr, m_to_idx;
  bit m_urg, m_first, m_held, m_to_err;

  always #5 clk = ~clk;

  mbox_cyc_arbiter #(
    .N_REQ   (N),
    .RR_MODE (1),
    .TO_W    (TOW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .urgent     (urgent),
    .cyc_done   (cyc_done),
    .retry      (retry),
    .pf_hold    (pf_hold),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .cyc_t0     (cyc_t0),
    .cyc_active (cyc_active),
    .to_err     (to_err),
    .to_idx     (to_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input logic [3:0] u, input int rr);
    for (int i = 0; i < N; i++) if (r[i] && u[i]) return i;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rr + k) % N;
      if (r[c] && !u[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_busy = 0; m_rr = 0; m_to_idx = 0;
    m_urg = 0; m_first = 0; m_held = 0; m_to_err = 0;
  endtask

  task automatic model_release();
    if (!m_urg) m_rr = (m_owner + 1) % N;
    m_owner = -1;
    m_first = 0;
  endtask

  task automatic model_step();
    m_to_err = 0;
    if (m_owner < 0) begin
      if (req != 0) begin
        m_urg   = |(req & urgent);
        m_owner = pick(req, urgent, m_rr);
        m_first = 1;
        m_busy  = 0;
      end
    end else if (m_held) begin
      if (!pf_hold) m_held = 0;
    end else if (pf_hold) begin
      m_held  = 1;
      m_first = 0;
    end else if (retry) begin
      m_first = 1;
      m_busy  = 0;
    end else if (cyc_done) begin
      model_release();
    end else if (m_first) begin
      m_first = 0;
      m_busy  = 0;
    end else begin
      m_busy++;
      if (m_busy == LAST) begin
        m_to_err = 1;
        m_to_idx = m_owner;
        model_release();
      end
    end
  endtask

  task automatic check_outputs();
    int exp_grant;
    exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
    check_eq("grant", grant, exp_grant);
    check_eq("cyc_active", cyc_active, m_owner >= 0);
    check_eq("cyc_t0", cyc_t0, m_first);
    check_eq("to_err", to_err, m_to_err);
    check_eq("to_idx", to_idx, m_to_idx);
    if (m_owner >= 0) check_eq("grant_idx", grant_idx, m_owner);
  endtask

  task automatic check_reset_state();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_grant_idx", grant_idx, 0);
    check_eq("rst_cyc_t0", cyc_t0, 0);
    check_eq("rst_cyc_active", cyc_active, 0);
    check_eq("rst_to_err", to_err, 0);
    check_eq("rst_to_idx", to_idx, 0);
  endtask

  initial begin
    int  mode;
    bit  expiring;
    rst_n = 1'b0; req = '0; urgent = '0; cyc_done = 0; retry = 0; pf_hold = 0;
    model_reset();
    #12;
    check_reset_state();
    rst_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      mode = (c / 400) % 4;
      // mode 0: general traffic; 1: rare done, forced collisions at expiry;
      // 2: no done (timeouts, long holds); 3: heavy urgent mix
      req = 4'($urandom);
      if ($urandom % 4 == 0) req = '0;
      if (mode == 3) urgent = 4'($urandom);
      else if ($urandom % 8 == 0) urgent = 4'(1 << ($urandom % 4));
      else urgent = '0;
      if (pf_hold) begin
        if ($urandom % ((mode == 2) ? 40 : 8) == 0) pf_hold = 0;
      end else if ($urandom % 24 == 0) begin
        pf_hold = 1;
      end
      retry = (mode == 0 || mode == 3) ? ($urandom % 12 == 0) : 1'b0;
      expiring = (m_owner >= 0) && !m_first && !m_held && (m_busy == LAST - 1) &&
                 !pf_hold && !retry;
      case (mode)
        1:       cyc_done = expiring ? 1'($urandom % 2) : ($urandom % 40 == 0);
        2:       cyc_done = 1'b0;
        default: cyc_done = ($urandom % 3 == 0);
      endcase

      @(posedge clk);
      model_step();
      #1;
      check_outputs();

      // Asynchronous reset between clock edges, sometimes in the middle of a cycle.
      if (c % 700 == 350 || (m_owner >= 0 && !m_first && $urandom % 300 == 0)) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
